// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle ARM controller.
// Contents: the FSM state enum, ALUControl codes, instruction Op codes,
// data-processing command codes and ARM condition codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  // ALUControl encodings
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Instruction class (Op field)
  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  // Data-processing commands (Funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ARM condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_logic.sv
// Condition logic: holds the NZCV flags register, evaluates the instruction
// condition against it and registers the result as cond_ex_r.
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   cond            instruction condition field
//   alu_flags       NZCV produced by the datapath ALU
//   flag_w          flag write requests {NZ, CV}, gated here by cond_ex_r
//   cond_ex_r       registered condition-passed, the only gating source
module cond_logic
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  output logic       cond_ex_r
);

  logic [3:0] flags;
  logic       cond_ex;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // cond_ex_r samples the flags as they stood before an EXECUTE-state write,
  // so an instruction's own writeback is gated by the pre-update flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags     <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      cond_ex_r <= cond_ex;
      if (flag_w[1] && cond_ex_r) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] && cond_ex_r) flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM controller: main FSM, ALU decoder, instruction decoder and
// conditional gating of the architectural write enables.
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   Cond, Op, Funct, Rd instruction fields from the instruction register
//   ALUFlags            datapath NZCV
//   PCWrite, MemWrite, RegWrite, IRWrite   write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc  selects
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl
);

  state_t     state;
  logic       reg_w, mem_w, branch, next_pc, ir_w;
  logic [1:0] alu_dec;
  logic       nz_ok, cv_ok, is_cmp;
  logic       in_execute;
  logic [1:0] flag_w;
  logic       cond_ex_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    state <= DECODE;
        DECODE: begin
          case (Op)
            OP_MEM:    state <= MEMADR;
            OP_DP:     state <= Funct[5] ? EXECUTEI : EXECUTER;
            OP_BRANCH: state <= BRANCH;
            default:   state <= FETCH;
          endcase
        end
        MEMADR:   state <= Funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:  state <= MEMWB;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        default:  state <= FETCH;
      endcase
    end
  end

  // ALU decoder; CMP is a SUB whose register writeback is dropped.
  // Unrecognised commands fall back to ADD with no flag update.
  always_comb begin
    alu_dec = ALU_ADD;
    nz_ok   = 1'b0;
    cv_ok   = 1'b0;
    is_cmp  = 1'b0;
    case (Funct[4:1])
      CMD_ADD: begin nz_ok = 1'b1; cv_ok = 1'b1; end
      CMD_SUB: begin alu_dec = ALU_SUB; nz_ok = 1'b1; cv_ok = 1'b1; end
      CMD_AND: begin alu_dec = ALU_AND; nz_ok = 1'b1; end
      CMD_ORR: begin alu_dec = ALU_ORR; nz_ok = 1'b1; end
      CMD_CMP: begin alu_dec = ALU_SUB; nz_ok = 1'b1; cv_ok = 1'b1; is_cmp = 1'b1; end
      default: ;
    endcase
  end

  // Controls are decoded straight from the state register so that FETCH's
  // enables are live in the first cycle after reset releases.
  always_comb begin
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    next_pc    = 1'b0;
    ir_w       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        ir_w = 1'b1; next_pc = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01; reg_w = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1; mem_w = 1'b1;
      end
      EXECUTER: ALUControl = alu_dec;
      EXECUTEI: begin
        ALUSrcB = 2'b01; ALUControl = alu_dec;
      end
      ALUWB:    reg_w = ~is_cmp;
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_execute = (state == EXECUTER) || (state == EXECUTEI);
  assign flag_w     = {nz_ok, cv_ok} & {2{in_execute & Funct[0]}};

  cond_logic u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (Cond),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .cond_ex_r (cond_ex_r)
  );

  // Enables are additionally qualified by reset so FETCH cannot write while
  // the controller is held in reset.
  assign PCWrite  = reset & (next_pc | ((branch | (reg_w & (Rd == 4'd15))) & cond_ex_r));
  assign RegWrite = reset & reg_w & cond_ex_r;
  assign MemWrite = reset & mem_w & cond_ex_r;
  assign IRWrite  = reset & ir_w;

  assign ImmSrc = Op;
  assign RegSrc = {Op == OP_MEM, Op == OP_BRANCH};

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have one clock and reset; reset is asynchronous and active-low.
REQ-002 SHALL expose: clk  in  1  rising-edge clock.
REQ-003 SHALL expose: reset  in  1  asynchronous, active-low (0 = in reset).
REQ-004 SHALL expose: Cond  in  4  instruction bits [31:28].
REQ-005 SHALL expose: Op  in  2  instruction bits [27:26].
REQ-006 SHALL expose: Funct  in  6  instruction bits [25:20] (I, cmd[3:0], S/L).
REQ-007 SHALL expose: Rd  in  4  instruction bits [15:12].
REQ-008 SHALL expose: ALUFlags  in  4  datapath NZCV.
REQ-009 SHALL expose: PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA  out  1 each  datapath enables and selects.
REQ-010 SHALL expose: RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl  out  2 each  datapath selects.

Function
REQ-011 SHALL sequence a multicycle ARM datapath with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-012 SHALL transition FETCH->DECODE unconditionally.
REQ-013 SHALL transition from DECODE on Op: 01->MEMADR; 00 with Funct[5]=0->EXECUTER; 00 with Funct[5]=1->EXECUTEI; 10->BRANCH; 11->FETCH (NOP).
REQ-014 SHALL transition MEMADR->MEMREAD if Funct[0]=1, else ->MEMWRITE.
REQ-015 SHALL transition MEMREAD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWRITE, ALUWB and BRANCH->FETCH.
REQ-016 SHALL drive in FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, PCWrite=1, ALUControl=00.
REQ-017 SHALL drive in DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00.
REQ-018 SHALL drive in MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00.
REQ-019 SHALL drive in MEMREAD: AdrSrc=1, ResultSrc=00. MEMWB: ResultSrc=01, RegW. MEMWRITE: AdrSrc=1, ResultSrc=00, MemW.
REQ-020 SHALL drive in EXECUTER: ALUSrcA=0, ALUSrcB=00, ALU-decode. EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALU-decode. ALUWB: ResultSrc=00, RegW.
REQ-021 SHALL drive in BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUControl=00, Branch.
REQ-022 SHALL hold all enables at 0 and all selects at 00 in any state not listed for them.
REQ-023 SHALL ALU-decode on Funct[4:1]: 0100->00 (ADD), 0010->01 (SUB), 0000->10 (AND), 1100->11 (ORR), 1010->01 (CMP, RegW suppressed).
REQ-024 SHALL decode any other Funct[4:1] to ALUControl=00 with flag write disabled.
REQ-025 SHALL drive ImmSrc=Op at all times, RegSrc[0]=(Op==10) and RegSrc[1]=(Op==01).
REQ-026 SHALL hold a 4-bit NZCV flags register and evaluate CondEx combinationally from Cond and that register for all 15 ARM codes (1110=always; 1111=never).
REQ-027 SHALL register CondEx every cycle into CondExR and use only CondExR for gating.
REQ-028 SHALL drive RegWrite=RegW&CondExR, MemWrite=MemW&CondExR and PCWrite=NextPC|((Branch|(RegW&Rd==15))&CondExR).
REQ-029 SHALL write flags in EXECUTER/EXECUTEI only when Funct[0]=1 and CondExR=1: NZ for all decoded ops; CV only for ADD/SUB/CMP.
REQ-030 SHALL make flags written in EXECUTE visible to CondEx from the next instruction onward; an instruction's own ALUWB gating SHALL be unaffected by its own flag write.

Reset
REQ-031 SHALL force state=FETCH, flags=0000 and CondExR=0 immediately when reset=0, independent of clk.
REQ-032 SHALL hold PCWrite, IRWrite, RegWrite and MemWrite at 0 while reset=0.
REQ-033 SHALL begin FETCH on the first rising edge after reset deasserts, including when reset was asserted mid-instruction.

Structure
REQ-034 SHALL place the state enum, ALUControl codes, Op codes and condition codes in shared package mc_pkg.
REQ-035 SHALL implement flags, CondEx and CondExR in sub-module cond_logic; the FSM and decoders SHALL stay in mc_controller.

Verification
REQ-036 SHALL cover ADD (Op=00, Funct=001000, Cond=1110): 4-cycle sequence; ALUControl=00 in EXECUTER; RegWrite=1 only in ALUWB.
REQ-037 SHALL cover LDR (Op=01, Funct=011001): 5 cycles; AdrSrc=1 in MEMREAD; RegWrite=1, ResultSrc=01 in MEMWB. STR (Funct=011000): MemWrite=1 in cycle 4 only.
REQ-038 SHALL cover SUBS with ALUFlags=0100, then ADDNE (Cond=0001): flags=0100 and RegWrite=0 in ALUWB.
REQ-039 SHALL cover B (Op=10, Cond=0000) with Z=1: PCWrite=1 in BRANCH; with Z=0: PCWrite=0 in BRANCH.
REQ-040 SHALL cover reset=0 asserted in MEMREAD: state FETCH within the same cycle with all enables 0, and LDR fully re-executed after release.
REQ-041 SHALL cover ADD with Rd=15: PCWrite=1 and ResultSrc=00 in ALUWB.
